a2_sign_restore: RTL

//  Output stage of the multiplier datapath: the inverse of the A2->sign/magnitude front end.
//  - Takes an unsigned magnitude result plus the two operand sign flags.
//  - Rebuilds the signed two's-complement value as a 2-stage valid/ready pipeline.
//  - The conditional-negate carry chain is split at LW to meet timing.
//  - Flags results that do not fit in DW signed bits.

---
 rtl/mult_pkg.sv | 12 +
 rtl/cond_negate_slice.sv | 13 +
 rtl/a2_sign_restore.sv | 79 +++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and stage-1 register layout for the multiplier output stage
package mult_pkg;
    localparam int DW_DEF = 32;
    typedef logic [DW_DEF-1:0] mag_t;
    typedef struct packed {
        logic [DW_DEF/2-1:0] lo;
        logic [DW_DEF/2-1:0] hi;
        logic c;
        logic neg;
        logic ovf;
    } s1_t;
endpackage

// File: rtl/cond_negate_slice.sv
// cond_negate_slice: one slice of the split two's-complement negate carry chain
module cond_negate_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    input  logic         cin,
    output logic [W-1:0] y,
    output logic         cout
);
    // invert and add the incoming carry only when negating; carry out feeds the next slice
    always_comb {cout, y} = neg ? {1'b0, ~x} + (W+1)'(cin) : {1'b0, x};
endmodule

// File: rtl/a2_sign_restore.sv
// a2_sign_restore: rebuilds a signed two's-complement result from magnitude and operand signs
module a2_sign_restore
    import mult_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = DW / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_Mag,
    input  logic          i_Signo_A,
    input  logic          i_Signo_B,
    input  logic          i_Valid,
    output logic          o_Ready,
    output logic [DW-1:0] o_Val,
    output logic          o_Signo,
    output logic          o_Ovf,
    output logic          o_Valid,
    input  logic          i_Ready
);
    typedef struct packed {
        logic [LW-1:0]    lo;
        logic [DW-LW-1:0] hi;
        logic             c;
        logic             neg;
        logic             ovf;
    } s1_t;

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    logic             neg, ovf, c1, unused_hi_cout;
    logic             v1, v2, acc, ld2;
    logic [LW-1:0]    lo1;
    logic [DW-LW-1:0] hi2;
    s1_t              s1;

    assign neg     = (i_Signo_A ^ i_Signo_B) && |i_Mag;
    assign ovf     = neg ? i_Mag > MIN_NEG : i_Mag >= MIN_NEG;
    assign o_Ready = !v1 || !v2 || i_Ready;
    assign acc     = i_Valid && o_Ready;
    assign ld2     = v1 && (!v2 || i_Ready);
    assign o_Valid = v2;

    cond_negate_slice #(.W(LW)) u_lo (
        .x(i_Mag[LW-1:0]), .neg(neg), .cin(1'b1), .y(lo1), .cout(c1)
    );

    cond_negate_slice #(.W(DW-LW)) u_hi (
        .x(s1.hi), .neg(s1.neg), .cin(s1.c), .y(hi2), .cout(unused_hi_cout)
    );

    // stage 1: low slice negated, high slice raw plus the carry into it
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else begin
            v1 <= acc || (v1 && !ld2);
            if (acc) s1 <= '{lo: lo1, hi: i_Mag[DW-1:LW], c: c1, neg: neg, ovf: ovf};
        end
    end

    // stage 2: finish the high slice and hold the result until downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            o_Val   <= '0;
            o_Signo <= 1'b0;
            o_Ovf   <= 1'b0;
        end else begin
            v2 <= ld2 || (v2 && !i_Ready);
            if (ld2) begin
                o_Val   <= {hi2, s1.lo};
                o_Signo <= s1.neg;
                o_Ovf   <= s1.ovf;
            end
        end
    end
endmodule
